// File: rtl/spi_client_frame.sv
// SPI target front end: oversamples spi_clk/cs/mosi in the clk domain, receives MSB-first
// CMD_W-bit words (several per frame), shifts a response out on MISO, hands words over valid/ready.
module spi_client_frame #(
  parameter int CMD_W       = 4,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_clk,
  input  logic             mosi,
  input  logic             cs,
  output logic             miso,
  output logic             miso_oe,
  input  logic [CMD_W-1:0] tx_data,
  output logic [CMD_W-1:0] command,
  output logic             command_valid,
  input  logic             command_ready,
  output logic             frame_error,
  output logic             overrun
);

  localparam logic           CLK_IDLE = (CPOL != 0);
  localparam logic           PHASE    = (CPHA != 0);
  localparam int             CNT_W    = (CMD_W > 2) ? $clog2(CMD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CMD_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, flush;
  logic                   sclk_prev, cs_prev, armed;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;
  logic                   start, stop, sample, shift, complete;
  logic [CNT_W-1:0]       rx_cnt;
  logic [CMD_W-2:0]       rx_shift;
  logic [CMD_W-1:0]       rx_word;
  logic [CMD_W-1:0]       tx_shift;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Stage: synchronisers. flush marks when the last stage holds a real pin sample rather than
  // its reset value, so a cs held low through reset can never look like an idle-high line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {SYNC_STAGES{CLK_IDLE}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      flush     <= '0;
      sclk_prev <= CLK_IDLE;
      cs_prev   <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      if (cs_s && flush[SYNC_STAGES-1])
        armed <= 1'b1;
    end
  end

  assign lead_edge   = (sclk_prev == CLK_IDLE) && (sclk_s != CLK_IDLE);
  assign trail_edge  = (sclk_prev != CLK_IDLE) && (sclk_s == CLK_IDLE);
  assign sample_edge = PHASE ? trail_edge : lead_edge;
  assign shift_edge  = PHASE ? lead_edge : trail_edge;
  assign rx_word     = {rx_shift, mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // cs release takes priority over any edge seen in the same cycle.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    stop       = 1'b0;
    sample     = 1'b0;
    shift      = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_prev && !cs_s && armed) begin
          start      = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_s) begin
          stop       = 1'b1;
          state_next = IDLE;
        end else begin
          sample   = sample_edge;
          shift    = shift_edge;
          complete = sample_edge && (rx_cnt == LAST_BIT);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage: frame control, MISO drive and output word register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt        <= '0;
      miso          <= 1'b0;
      miso_oe       <= 1'b0;
      frame_error   <= 1'b0;
      overrun       <= 1'b0;
      command       <= '0;
      command_valid <= 1'b0;
    end else begin
      frame_error <= stop && (rx_cnt != '0);
      overrun     <= 1'b0;
      if (start) begin
        rx_cnt  <= '0;
        miso_oe <= 1'b1;
        miso    <= tx_data[CMD_W-1];
      end
      if (stop) begin
        rx_cnt  <= '0;
        miso_oe <= 1'b0;
        miso    <= 1'b0;
      end
      if (sample)
        rx_cnt <= complete ? '0 : rx_cnt + 1'b1;
      if (shift)
        miso <= tx_shift[CMD_W-1];
      if (complete) begin
        if (command_valid && !command_ready) begin
          overrun <= 1'b1;
        end else begin
          command       <= rx_word;
          command_valid <= 1'b1;
        end
      end else if (command_valid && command_ready) begin
        command_valid <= 1'b0;
      end
    end
  end

  // With CPHA=0 the MSB already sits on MISO at frame start, so only the remaining bits are queued.
  always_ff @(posedge clk) begin
    if (start)
      tx_shift <= PHASE ? tx_data : (tx_data << 1);
    else if (complete)
      tx_shift <= tx_data;
    else if (shift)
      tx_shift <= tx_shift << 1;
    if (sample)
      rx_shift <= rx_word[CMD_W-2:0];
  end

endmodule

// File: tb/tb_spi_client_frame.sv
// Bench for spi_client_frame: three instances (4-bit mode 0, 8-bit mode 0, 8-bit mode 3)
// driven by a bit-level SPI controller model, with expected-word queues as the scoreboard.
module tb_spi_client_frame;
  localparam int H = 40;

  logic       clk = 1'b0;
  logic       rst_n, sclk, mosi, cs_a, cs_b, cs_c, rdy_a, rdy_b, rdy_c;
  logic [3:0] tx_a, cmd_a;
  logic [7:0] tx_b, cmd_b, tx_c, cmd_c;
  logic       miso_a, oe_a, vld_a, fe_a_o, ov_a_o;
  logic       miso_b, oe_b, vld_b, fe_b_o, ov_b_o;
  logic       miso_c, oe_c, vld_c, fe_c_o, ov_c_o;

  always #5 clk = ~clk;

  spi_client_frame #(.CMD_W(4), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .spi_clk(sclk), .mosi(mosi), .cs(cs_a), .miso(miso_a),
    .miso_oe(oe_a), .tx_data(tx_a), .command(cmd_a), .command_valid(vld_a),
    .command_ready(rdy_a), .frame_error(fe_a_o), .overrun(ov_a_o));

  spi_client_frame #(.CMD_W(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .spi_clk(sclk), .mosi(mosi), .cs(cs_b), .miso(miso_b),
    .miso_oe(oe_b), .tx_data(tx_b), .command(cmd_b), .command_valid(vld_b),
    .command_ready(rdy_b), .frame_error(fe_b_o), .overrun(ov_b_o));

  spi_client_frame #(.CMD_W(8), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .spi_clk(sclk), .mosi(mosi), .cs(cs_c), .miso(miso_c),
    .miso_oe(oe_c), .tx_data(tx_c), .command(cmd_c), .command_valid(vld_c),
    .command_ready(rdy_c), .frame_error(fe_c_o), .overrun(ov_c_o));

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q_a[$], got_q_a[$];
  logic [7:0] exp_q_b[$], got_q_b[$], exp_q_c[$], got_q_c[$];
  int fe_a = 0, ov_a = 0, vcyc_a = 0, fe_b = 0, ov_b = 0, fe_c = 0, ov_c = 0;

  // Record every handshake and pulse, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vld_a && rdy_a) got_q_a.push_back(cmd_a);
      if (vld_b && rdy_b) got_q_b.push_back(cmd_b);
      if (vld_c && rdy_c) got_q_c.push_back(cmd_c);
      if (vld_a)  vcyc_a++;
      if (fe_a_o) fe_a++;
      if (ov_a_o) ov_a++;
      if (fe_b_o) fe_b++;
      if (ov_b_o) ov_b++;
      if (fe_c_o) fe_c++;
      if (ov_c_o) ov_c++;
    end
  end

  function automatic logic miso_of(input int which);
    case (which)
      0:       return miso_a;
      1:       return miso_b;
      default: return miso_c;
    endcase
  endfunction

  task automatic cs_set(input int which, input logic v);
    case (which)
      0:       cs_a = v;
      1:       cs_b = v;
      default: cs_c = v;
    endcase
  endtask

  task automatic frame_start(input int which);
    sclk = (which == 2);
    #H;
    cs_set(which, 1'b0);
    #(2 * H);
  endtask

  task automatic frame_end(input int which);
    #H;
    cs_set(which, 1'b1);
    repeat (20) @(posedge clk);
    #1;
  endtask

  // Controller model: n bits MSB-first; MISO captured just before each sample edge.
  task automatic xfer(input int which, input int n, input logic [31:0] bits, output logic [31:0] got);
    logic cpol, cpha;
    cpol = (which == 2);
    cpha = (which == 2);
    got  = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (cpha) begin
        sclk = ~cpol;
        mosi = bits[i];
        #H;
        got[i] = miso_of(which);
        sclk = cpol;
        #H;
      end else begin
        mosi = bits[i];
        #H;
        got[i] = miso_of(which);
        sclk = ~cpol;
        #H;
        sclk = cpol;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0;
    cs_a = 1'b1; cs_b = 1'b1; cs_c = 1'b1;
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    tx_a = 4'h0; tx_b = 8'h0; tx_c = 8'h0;
    #23;
    checks++;
    if ({miso_a, oe_a, vld_a, fe_a_o, ov_a_o, cmd_a} !== 9'h0) begin
      failures++; $display("FAIL reset_a got=%h exp=0", {miso_a, oe_a, vld_a, fe_a_o, ov_a_o, cmd_a});
    end
    checks++;
    if ({miso_b, oe_b, vld_b, fe_b_o, ov_b_o, cmd_b} !== 13'h0) begin
      failures++; $display("FAIL reset_b got=%h exp=0", {miso_b, oe_b, vld_b, fe_b_o, ov_b_o, cmd_b});
    end
    checks++;
    if ({miso_c, oe_c, vld_c, fe_c_o, ov_c_o, cmd_c} !== 13'h0) begin
      failures++; $display("FAIL reset_c got=%h exp=0", {miso_c, oe_c, vld_c, fe_c_o, ov_c_o, cmd_c});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({oe_a, vld_a, oe_b, vld_b, oe_c, vld_c} !== 6'b0) begin
      failures++; $display("FAIL post_reset_idle got=%b exp=000000", {oe_a, vld_a, oe_b, vld_b, oe_c, vld_c});
    end
  endtask

  task automatic test_single_word();
    logic [31:0] got;
    logic [3:0]  e, g;
    int v0, f0, o0;
    rdy_a = 1'b1; tx_a = 4'h9;
    v0 = vcyc_a; f0 = fe_a; o0 = ov_a;
    exp_q_a.push_back(4'hA);
    frame_start(0);
    checks++;
    if (oe_a !== 1'b1) begin failures++; $display("FAIL t1_oe_active got=%b exp=1", oe_a); end
    xfer(0, 4, 32'hA, got);
    frame_end(0);
    checks++;
    if (got[3:0] !== 4'h9) begin failures++; $display("FAIL t1_miso got=%h exp=9", got[3:0]); end
    checks++;
    if ({oe_a, miso_a} !== 2'b00) begin failures++; $display("FAIL t1_oe_idle got=%b exp=00", {oe_a, miso_a}); end
    checks++;
    if (vcyc_a - v0 != 1) begin failures++; $display("FAIL t1_valid_cycles got=%0d exp=1", vcyc_a - v0); end
    checks++;
    if (fe_a != f0 || ov_a != o0) begin
      failures++; $display("FAIL t1_errors got_fe=%0d got_ov=%0d exp=0,0", fe_a - f0, ov_a - o0);
    end
    while (exp_q_a.size() > 0) begin
      checks++;
      e = exp_q_a.pop_front();
      if (got_q_a.size() == 0) begin failures++; $display("FAIL t1_cmd got=none exp=%h", e); end
      else begin
        g = got_q_a.pop_front();
        if (g !== e) begin failures++; $display("FAIL t1_cmd got=%h exp=%h", g, e); end
      end
    end
    checks++;
    if (got_q_a.size() != 0) begin failures++; $display("FAIL t1_extra got=%0d exp=0", got_q_a.size()); got_q_a.delete(); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    logic [7:0]  e, g;
    rdy_b = 1'b1; tx_b = 8'hE7;
    exp_q_b.push_back(8'h3C);
    exp_q_b.push_back(8'hC3);
    frame_start(1);
    xfer(1, 16, 32'h3CC3, got);
    frame_end(1);
    checks++;
    if (got[15:0] !== 16'hE7E7) begin failures++; $display("FAIL t2_miso got=%h exp=e7e7", got[15:0]); end
    checks++;
    if (fe_b != 0 || ov_b != 0) begin failures++; $display("FAIL t2_errors got_fe=%0d got_ov=%0d exp=0,0", fe_b, ov_b); end
    while (exp_q_b.size() > 0) begin
      checks++;
      e = exp_q_b.pop_front();
      if (got_q_b.size() == 0) begin failures++; $display("FAIL t2_cmd got=none exp=%h", e); end
      else begin
        g = got_q_b.pop_front();
        if (g !== e) begin failures++; $display("FAIL t2_cmd got=%h exp=%h", g, e); end
      end
    end
    checks++;
    if (got_q_b.size() != 0) begin failures++; $display("FAIL t2_extra got=%0d exp=0", got_q_b.size()); got_q_b.delete(); end
  endtask

  task automatic test_mode3();
    logic [31:0] got;
    logic [7:0]  e, g;
    rdy_c = 1'b1; tx_c = 8'h5A;
    exp_q_c.push_back(8'h81);
    frame_start(2);
    xfer(2, 8, 32'h81, got);
    frame_end(2);
    checks++;
    if (got[7:0] !== 8'h5A) begin failures++; $display("FAIL t3_miso got=%h exp=5a", got[7:0]); end
    checks++;
    if (fe_c != 0 || ov_c != 0) begin failures++; $display("FAIL t3_errors got_fe=%0d got_ov=%0d exp=0,0", fe_c, ov_c); end
    while (exp_q_c.size() > 0) begin
      checks++;
      e = exp_q_c.pop_front();
      if (got_q_c.size() == 0) begin failures++; $display("FAIL t3_cmd got=none exp=%h", e); end
      else begin
        g = got_q_c.pop_front();
        if (g !== e) begin failures++; $display("FAIL t3_cmd got=%h exp=%h", g, e); end
      end
    end
    checks++;
    if (got_q_c.size() != 0) begin failures++; $display("FAIL t3_extra got=%0d exp=0", got_q_c.size()); got_q_c.delete(); end
  endtask

  task automatic test_frame_error();
    logic [31:0] got;
    logic [3:0]  e, g;
    int f0, v0;
    rdy_a = 1'b1;
    f0 = fe_a; v0 = vcyc_a;
    frame_start(0);
    xfer(0, 3, 32'b011, got);
    frame_end(0);
    checks++;
    if (fe_a - f0 != 1) begin failures++; $display("FAIL t4_frame_error got=%0d exp=1", fe_a - f0); end
    checks++;
    if (vcyc_a != v0 || got_q_a.size() != 0) begin
      failures++; $display("FAIL t4_no_word got_valid_cycles=%0d exp=0", vcyc_a - v0);
      got_q_a.delete();
    end
    exp_q_a.push_back(4'h6);
    frame_start(0);
    xfer(0, 4, 32'h6, got);
    frame_end(0);
    checks++;
    if (fe_a - f0 != 1) begin failures++; $display("FAIL t4_no_new_error got=%0d exp=1", fe_a - f0); end
    while (exp_q_a.size() > 0) begin
      checks++;
      e = exp_q_a.pop_front();
      if (got_q_a.size() == 0) begin failures++; $display("FAIL t4_cmd got=none exp=%h", e); end
      else begin
        g = got_q_a.pop_front();
        if (g !== e) begin failures++; $display("FAIL t4_cmd got=%h exp=%h", g, e); end
      end
    end
  endtask

  task automatic test_overrun();
    logic [31:0] got;
    logic [3:0]  e, g;
    int o0;
    rdy_a = 1'b0;
    o0 = ov_a;
    exp_q_a.push_back(4'h1);
    frame_start(0);
    xfer(0, 8, 32'h12, got);
    frame_end(0);
    checks++;
    if (ov_a - o0 != 1) begin failures++; $display("FAIL t5_overrun got=%0d exp=1", ov_a - o0); end
    checks++;
    if ({vld_a, cmd_a} !== 5'b1_0001) begin failures++; $display("FAIL t5_held got=%b exp=10001", {vld_a, cmd_a}); end
    @(posedge clk); #1;
    rdy_a = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (vld_a !== 1'b0) begin failures++; $display("FAIL t5_valid_drop got=%b exp=0", vld_a); end
    while (exp_q_a.size() > 0) begin
      checks++;
      e = exp_q_a.pop_front();
      if (got_q_a.size() == 0) begin failures++; $display("FAIL t5_cmd got=none exp=%h", e); end
      else begin
        g = got_q_a.pop_front();
        if (g !== e) begin failures++; $display("FAIL t5_cmd got=%h exp=%h", g, e); end
      end
    end
    checks++;
    if (got_q_a.size() != 0) begin failures++; $display("FAIL t5_extra got=%0d exp=0", got_q_a.size()); got_q_a.delete(); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] got;
    logic [3:0]  e, g;
    int f0, v0;
    rdy_a = 1'b1;
    frame_start(0);
    xfer(0, 2, 32'b11, got);
    rst_n = 1'b0;
    #20;
    checks++;
    if ({oe_a, miso_a, vld_a} !== 3'b000) begin failures++; $display("FAIL t6_in_reset got=%b exp=000", {oe_a, miso_a, vld_a}); end
    rst_n = 1'b1;
    f0 = fe_a; v0 = vcyc_a;
    repeat (10) @(posedge clk);
    #1;
    xfer(0, 4, 32'hF, got);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({oe_a, vld_a} !== 2'b00 || vcyc_a != v0) begin
      failures++; $display("FAIL t6_ignored got_oe_vld=%b valid_cycles=%0d exp=00,0", {oe_a, vld_a}, vcyc_a - v0);
    end
    frame_end(0);
    checks++;
    if (fe_a != f0) begin failures++; $display("FAIL t6_no_error got=%0d exp=0", fe_a - f0); end
    got_q_a.delete();
    exp_q_a.push_back(4'hF);
    frame_start(0);
    xfer(0, 4, 32'hF, got);
    frame_end(0);
    while (exp_q_a.size() > 0) begin
      checks++;
      e = exp_q_a.pop_front();
      if (got_q_a.size() == 0) begin failures++; $display("FAIL t6_cmd got=none exp=%h", e); end
      else begin
        g = got_q_a.pop_front();
        if (g !== e) begin failures++; $display("FAIL t6_cmd got=%h exp=%h", g, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_mode3();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
